rr_arbiter_ctrl: RTL
====================

Name: rr_arbiter_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one resource between four requesters (req[0..3]).
- Sequences each access through arbitrate, grant, hold and release phases.
- The resource reports completion with `done`.
- A hold timer force-releases a requester that holds the resource too long.
- Sits in front of the shared datapath; the encoded grant drives the resource's input mux select.

Parameters:
- MAX_HOLD, 8: maximum number of cycles a grant may stay in GRANT before forced release (legal range 2..15).
- CNT_W, 4: hold counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset; rst=0 forces reset state immediately.
- en  in  1  arbitration enable; gates the start of new arbitrations only.
- req  in  4  request lines, one per requester; level-sensitive.
- done  in  1  resource completion strobe for the current grant.
- gnt  out  4  one-hot grant, registered.
- gnt_id  out  2  encoded index of the current/last granted requester, registered.
- gnt_valid  out  1  equals |gnt.
- timeout  out  1  one-cycle pulse when a grant is force-released by the hold timer.
- state  out  2  FSM state for debug.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE(00), gnt=0000, gnt_id=00, gnt_valid=0, timeout=0, hold counter=0, last_id=3. With last_id=3, req[0] has top priority after reset.
- State encoding: IDLE=00, ARB=01, GRANT=10, RELEASE=11.
- IDLE: gnt=0. Moves to ARB when en=1 and req!=0; otherwise stays in IDLE.
- ARB (exactly 1 cycle):
  - Searches req starting at (last_id+1) mod 4 and wrapping; the first set bit wins.
  - The winner is registered into gnt/gnt_id on the exit edge; the state moves to GRANT.
  - If req==0 in this cycle, returns to IDLE with gnt unchanged at 0.
  - en is not re-checked in ARB.
- GRANT:
  - gnt is held stable; the hold counter increments by 1 every cycle, starting at 0 on entry.
  - Exit to RELEASE at the first edge where any of these holds: done=1; req[gnt_id]=0 (requester withdrew); counter==MAX_HOLD-1.
  - On exit, last_id<=gnt_id and the counter clears.
  - timeout=1 for one cycle (registered, coincident with the RELEASE cycle) only when the exit cause is the counter.
  - Priority on simultaneous events: done, then withdraw, then timeout. A timeout coinciding with done or withdraw does not pulse timeout.
- RELEASE (exactly 1 cycle):
  - gnt=0 (mandatory dead cycle; no two grants are ever adjacent); gnt_id keeps the last value.
  - Next state is ARB if en=1 and req!=0, else IDLE.
- en=0 never aborts a grant in progress; it only blocks IDLE→ARB and RELEASE→ARB.
- Latency:
  - req sampled in IDLE at edge k → ARB after k → gnt asserted after edge k+1.
  - Minimum period between consecutive grants is 1 GRANT cycle + RELEASE + ARB.
- gnt is always one-hot or zero; gnt changes only on the edges entering GRANT (set) and entering RELEASE (clear).
- done outside GRANT is ignored.
- Reset mid-grant: gnt drops asynchronously and the fairness pointer returns to last_id=3.

Test Plan:
1. Reset/priority: rst=0 for 10 ns, then 1; en=1, req=1111 → ARB, then gnt=0001, gnt_id=00. Pulse done → RELEASE (gnt=0000), then gnt=0010. Repeat → 0100, then 1000, then wraps to 0001.
2. Timeout: MAX_HOLD=8, req=0100 held, done=0 → gnt=0100 for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0000. Re-grant to 0100 after ARB.
3. Withdraw: granted req[1], drop req[1] after 3 GRANT cycles → RELEASE on the next edge, timeout=0. req=1001 then grants 1000 (search starts at index 2).
4. Simultaneous: done=1 in the same cycle the counter reaches MAX_HOLD-1 → release with timeout=0. en=0 during GRANT → grant continues until done, then IDLE with gnt=0000 while req stays 1111.
5. Async reset mid-operation: rst=0 between edges while gnt=0100 → gnt=0000, state=00 immediately. After release with req=0110, gnt=0010 first (last_id reset to 3).
6. Idle stability: en=1, req=0000 for 10 cycles → state stays 00, gnt=0000, timeout never asserted. Random req/done run: gnt always one-hot or zero, with at least 1 zero cycle between grants.

Source files
------------

// File: rtl/rr_arbiter_ctrl_if.sv
// Request/grant bundle between the four requesters and the round-robin
// arbiter. The master side drives the requests and the completion strobe.
// The slave side is the arbiter, which returns the grant and debug status.
interface rr_arbiter_ctrl_if;
  logic       en;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] state;

  // Requester / resource side
  modport master (
    output en,
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout,
    input  state
  );

  // Arbiter side
  modport slave (
    input  en,
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout,
    output state
  );
endinterface

// File: rtl/rr_arbiter_ctrl.sv
// Round-robin arbiter and sequencer for one resource shared by four requesters.
// Each access passes through ARB, GRANT and RELEASE. RELEASE is a one-cycle
// dead slot, so two grants are never back to back. A hold counter
// force-releases a grant that has been held for MAX_HOLD cycles.
// The encoded grant drives the input mux select of the shared datapath.
module rr_arbiter_ctrl #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARB     = 2'b01,
    GRANT   = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam int unsigned HOLD_LAST = MAX_HOLD - 1;

  state_t           state_q;
  logic [3:0]       gnt_q;
  logic [1:0]       gntId_q;
  logic [1:0]       lastId_q;
  logic [CNT_W-1:0] holdCnt_q;
  logic [CNT_W-1:0] holdCnt_d;
  logic             timeout_q;

  logic             winFound;
  logic [1:0]       winId;
  logic [1:0]       probeIdx;
  logic [3:0]       winOneHot;

  logic             doneHit;
  logic             withdrawHit;
  logic             limitHit;
  logic             grantExit;
  logic             forcedExit;
  logic             newWork;

  // Rotating priority search that starts one past the last served requester.
  // The loop walks offsets from farthest to nearest so the nearest set
  // request is the one left in winId.
  always_comb begin
    winFound = 1'b0;
    winId    = lastId_q;
    probeIdx = lastId_q;
    for (int k = 4; k >= 1; k--) begin
      probeIdx = lastId_q + 2'(k);
      if (bus.req[probeIdx]) begin
        winFound = 1'b1;
        winId    = probeIdx;
      end
    end
    winOneHot = 4'b0001 << winId;
  end

  // GRANT exit causes. done has priority, then withdraw, then the hold limit.
  // A timeout is reported only when the limit is the sole reason to leave.
  always_comb begin
    doneHit     = bus.done;
    withdrawHit = ~bus.req[gntId_q];
    limitHit    = (holdCnt_q == CNT_W'(HOLD_LAST));
    grantExit   = doneHit | withdrawHit | limitHit;
    forcedExit  = limitHit & ~doneHit & ~withdrawHit;
    holdCnt_d   = holdCnt_q + 1'b1;
    newWork     = bus.en & (|bus.req);
  end

  // Sequencer FSM. All outputs are registered here, so the grant changes
  // only on the edges that enter GRANT or enter RELEASE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      gntId_q   <= 2'b00;
      lastId_q  <= 2'b11;
      holdCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gnt_q <= 4'b0000;
          if (newWork) begin
            state_q <= ARB;
          end
        end
        ARB: begin
          if (winFound) begin
            gnt_q     <= winOneHot;
            gntId_q   <= winId;
            holdCnt_q <= '0;
            state_q   <= GRANT;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (grantExit) begin
            gnt_q     <= 4'b0000;
            lastId_q  <= gntId_q;
            holdCnt_q <= '0;
            timeout_q <= forcedExit;
            state_q   <= RELEASE;
          end else begin
            holdCnt_q <= holdCnt_d;
          end
        end
        RELEASE: begin
          gnt_q <= 4'b0000;
          if (newWork) begin
            state_q <= ARB;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          gnt_q   <= 4'b0000;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gntId_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;

endmodule
